forwarding_scoreboard: RTL and testbench
========================================

// Module: forwarding_scoreboard
// PURPOSE
//  Parametrised forwarding and hazard unit for the ARM pipeline. Keeps a shadow
//  pipeline of in-flight writers (dst, wb_en, is_load) from EX through WB.
//  Drives per-operand forwarding selects for the instruction in EX, and a
//  load-use / no-forward stall request for ID. Counts stall cycles.
// PARAMETERS
//  RW        4   register address width
//  NUM_SRC   2   source operands per instruction
//  DEPTH     2   forwardable stages after EX (slot1=MEM ... slotDEPTH=WB); min 2
//  LOAD_SLOT 2   first slot whose load data is forwardable; 1 <= LOAD_SLOT <= DEPTH
//  CNT_W     16  stall counter width
//  SEL_W = clog2(DEPTH+1) (localparam)
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              synchronous reset, active-high
//  hold         in   1              freeze: shadow pipeline does not advance
//  flush        in   1              squash the instruction entering EX (taken branch)
//  fwd_en       in   1              1 = forwarding mode, 0 = stall-only mode
//  id_valid     in   1              ID holds a real instruction
//  id_src       in   NUM_SRC*RW     ID source regs; operand i = [i*RW +: RW]
//  id_src_used  in   NUM_SRC        operand i actually read
//  id_dst       in   RW             ID destination reg
//  id_wb_en     in   1              ID instruction writes back
//  id_is_load   in   1              ID instruction is a load
//  stall        out  1              hold PC/IF-ID, insert bubble into EX (comb.)
//  ex_sel       out  NUM_SRC*SEL_W  operand i: 0 = regfile, s = forward from slot s (comb.)
//  stall_count  out  CNT_W          saturating count of stall cycles
// BEHAVIOUR
//  - State: slots 0..DEPTH, each {valid, dst, wb_en, is_load}. Slot 0 (EX) also
//    holds src[NUM_SRC] and src_used.
//  - Reset: all slots valid=0, wb_en=0. stall_count=0. Hence stall=0, ex_sel=0.
//  - Advance, every posedge with rst=0, hold=0:
//    - slot s <= slot s-1 for s >= 1.
//    - slot0 <= bubble (valid=0, wb_en=0) if flush|stall|!id_valid, else the ID fields.
//  - hold=1: all slots keep their value and stall_count keeps its value. Outputs are
//    still evaluated combinationally. rst takes priority over hold.
//  - A slot matches a reg r when valid & wb_en & dst==r.
//  - ex_sel[i] (fwd_en=1, slot0.valid, slot0.src_used[i]): the smallest s in
//    1..DEPTH whose slot matches slot0.src[i], else 0. The newest writer wins.
//    Otherwise ex_sel[i]=0.
//  - A matching load in slot s < LOAD_SLOT while its consumer is in EX is
//    illegal. The stall rule prevents it, and the bench asserts it never occurs.
//  - stall (id_valid=1, some used ID src i):
//    - fwd_en=1: stall if some slot j <= LOAD_SLOT-2 matches src i and holds a load.
//    - fwd_en=0: stall if some slot j in 0..DEPTH-1 matches src i. The WB slot is
//      excluded because the regfile is written before it is read.
//    - id_valid=0 gives stall=0. flush forces stall=0 (the squash wins).
//  - Latency: forwarding is 0-cycle; selects follow the slot contents combinationally.
//    A load-use hazard costs LOAD_SLOT-1 bubbles with forwarding.
//  - stall_count: +1 on each non-hold, non-reset cycle with stall=1. Saturates at
//    2^CNT_W-1, no wrap.
//  - rst asserted mid-hazard: the next cycle shows stall=0, all ex_sel=0, all slots empty.
//  - A mode change (fwd_en toggle) takes effect the same cycle. Slots are not cleared.
// TESTING
//  - Back-to-back ALU: ADD r3 then SUB r4,r3,r3 (fwd_en=1) -> the cycle after, ex_sel op0=op1=1, stall=0.
//  - Distance 2: write r5, one unrelated instr, then read r5 -> ex_sel=2; write r5 in MEM and in WB
//    at the same time -> ex_sel=1 (newest).
//  - Load-use: LDR r2 then ADD r1,r2,r0 -> stall=1 for exactly 1 cycle, then ex_sel op0=2, stall_count=1.
//  - fwd_en=0 with dependent pair -> stall=1 for 2 cycles (DEPTH=2), ex_sel stays 0, stall_count=2.
//  - flush during load-use stall -> stall=0, slot0 becomes a bubble; hold=1 for 3 cycles -> ex_sel and
//    stall_count are unchanged; rst mid-stall -> stall=0 and stall_count=0 on the next cycle.
//  - Saturation with CNT_W=3: 9 stall cycles -> stall_count=7. Unused src (id_src_used=0) matching
//    r2 -> no stall, ex_sel=0.

Source files
------------

// File: rtl/forwarding_scoreboard.sv
// -----------------------------------------------------------------------------
// forwarding_scoreboard
//
// Forwarding and hazard unit for the ARM pipeline. It keeps a shadow copy of
// every in-flight writer from EX (slot 0) through WB (slot DEPTH). From that
// copy it produces:
//   * per-operand forwarding selects for the instruction currently in EX
//   * a stall request for ID on load-use hazards (forwarding mode) or on any
//     pending writer (stall-only mode)
//   * a saturating count of the cycles spent stalled
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   hold         in   freeze the shadow pipeline and the stall counter
//   flush        in   squash the instruction entering EX (taken branch)
//   fwd_en       in   1 = forwarding mode, 0 = stall-only mode
//   id_valid     in   ID holds a real instruction
//   id_src       in   ID source registers, operand i at [i*RW +: RW]
//   id_src_used  in   operand i is actually read
//   id_dst       in   ID destination register
//   id_wb_en     in   ID instruction writes back
//   id_is_load   in   ID instruction is a load
//   stall        out  hold PC/IF-ID and inject a bubble into EX (combinational)
//   ex_sel       out  operand i: 0 = regfile, s = forward from slot s (comb.)
//   stall_count  out  saturating count of stall cycles
// -----------------------------------------------------------------------------
module forwarding_scoreboard #(
  parameter  int RW        = 4,
  parameter  int NUM_SRC   = 2,
  parameter  int DEPTH     = 2,
  parameter  int LOAD_SLOT = 2,
  parameter  int CNT_W     = 16,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic                     flush,
  input  logic                     fwd_en,
  input  logic                     id_valid,
  input  logic [NUM_SRC*RW-1:0]    id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic [RW-1:0]            id_dst,
  input  logic                     id_wb_en,
  input  logic                     id_is_load,
  output logic                     stall,
  output logic [NUM_SRC*SEL_W-1:0] ex_sel,
  output logic [CNT_W-1:0]         stall_count
);

  // Shadow pipeline: index 0 = EX, index DEPTH = WB.
  logic              r_vld [0:DEPTH];
  logic              r_wb  [0:DEPTH];
  logic              r_ld  [0:DEPTH];
  logic [RW-1:0]     r_dst [0:DEPTH];
  // Operand info is only needed for the instruction sitting in EX.
  logic [NUM_SRC*RW-1:0] r_src;
  logic [NUM_SRC-1:0]    r_src_used;
  logic [CNT_W-1:0]      r_cnt;

  logic                     w_hazard;
  logic                     w_stall;
  logic                     w_issue;
  logic [NUM_SRC*SEL_W-1:0] w_sel;

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ID-stage hazard detection against every occupied slot.
  // Forwarding mode only stalls while a load is too young to forward from
  // (slots before LOAD_SLOT-1 when the consumer would reach EX). Stall-only
  // mode waits until the writer reaches WB, which writes the regfile before
  // it is read.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i]) begin
        for (int j = 0; j <= DEPTH; j++) begin
          if (r_vld[j] && r_wb[j] && (r_dst[j] == id_src[i*RW +: RW])) begin
            if (fwd_en) begin
              if ((j < LOAD_SLOT - 1) && r_ld[j]) w_hazard = 1'b1;
            end else if (j < DEPTH) begin
              w_hazard = 1'b1;
            end
          end
        end
      end
    end
  end

  // A squash beats a stall: the ID instruction is being discarded anyway.
  assign w_stall = id_valid & ~flush & w_hazard;
  assign w_issue = id_valid & ~flush & ~w_stall;

  // EX-stage forwarding select. Scanning from the oldest slot towards the
  // newest lets the youngest matching writer overwrite older matches.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int s = DEPTH; s >= 1; s--) begin
        if (fwd_en && r_vld[0] && r_src_used[i] && r_vld[s] && r_wb[s] &&
            (r_dst[s] == r_src[i*RW +: RW])) begin
          w_sel[i*SEL_W +: SEL_W] = SEL_W'(s);
        end
      end
    end
  end

  // ID -> EX -> ... -> WB boundary: control fields, reset to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= DEPTH; s++) begin
        r_vld[s] <= 1'b0;
        r_wb[s]  <= 1'b0;
      end
      r_cnt <= '0;
    end else if (!hold) begin
      for (int s = 1; s <= DEPTH; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_wb[s]  <= r_wb[s-1];
      end
      r_vld[0] <= w_issue;
      r_wb[0]  <= w_issue & id_wb_en;
      if (w_stall) r_cnt <= f_sat_inc(r_cnt);
    end
  end

  // ID -> EX -> ... -> WB boundary: data fields, qualified by r_vld/r_wb.
  always_ff @(posedge clk) begin
    if (!hold) begin
      for (int s = 1; s <= DEPTH; s++) begin
        r_dst[s] <= r_dst[s-1];
        r_ld[s]  <= r_ld[s-1];
      end
      r_dst[0]   <= id_dst;
      r_ld[0]    <= id_is_load;
      r_src      <= id_src;
      r_src_used <= id_src_used;
    end
  end

  assign stall       = w_stall;
  assign ex_sel      = w_sel;
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
module tb_forwarding_scoreboard;

  localparam int RW        = 4;
  localparam int NUM_SRC   = 2;
  localparam int DEPTH     = 2;
  localparam int LOAD_SLOT = 2;
  localparam int SEL_W     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, hold, flush, fwd_en, id_valid;
  logic [NUM_SRC*RW-1:0]    id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [RW-1:0]            id_dst;
  logic                     id_wb_en, id_is_load;
  logic                     stall, stall_s;
  logic [NUM_SRC*SEL_W-1:0] ex_sel, ex_sel_s;
  logic [15:0]              stall_count;
  logic [2:0]               stall_count_s;

  forwarding_scoreboard #(.RW(RW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
                          .LOAD_SLOT(LOAD_SLOT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .fwd_en(fwd_en),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dst(id_dst), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
    .stall(stall), .ex_sel(ex_sel), .stall_count(stall_count));

  // Same stimulus, narrow counter to observe saturation.
  forwarding_scoreboard #(.RW(RW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
                          .LOAD_SLOT(LOAD_SLOT), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .fwd_en(fwd_en),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dst(id_dst), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
    .stall(stall_s), .ex_sel(ex_sel_s), .stall_count(stall_count_s));

  localparam int K_STALL = 0, K_SEL0 = 1, K_SEL1 = 2, K_CNT = 3, K_CNTS = 4;

  typedef struct {
    int    cyc;
    int    kind;
    int    exp;
    string name;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int kind);
    case (kind)
      K_STALL: return int'(stall);
      K_SEL0:  return int'(ex_sel[1:0]);
      K_SEL1:  return int'(ex_sel[3:2]);
      K_CNT:   return int'(stall_count);
      default: return int'(stall_count_s);
    endcase
  endfunction

  // Monitor: pops every expectation tagged for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    int   sel;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.name, e.cyc, cyc);
      end else begin
        a = actual(e.kind);
        if (a != e.exp) begin
          errors++;
          $display("FAIL %s: cycle %0d got %0d expected %0d", e.name, cyc, a, e.exp);
        end
      end
    end
    // A load must never be forwarded from a slot before LOAD_SLOT.
    for (int i = 0; i < NUM_SRC; i++) begin
      sel = int'(ex_sel[i*SEL_W +: SEL_W]);
      if (fwd_en && sel != 0 && sel < LOAD_SLOT) begin
        checks++;
        if (dut.r_ld[sel]) begin
          errors++;
          $display("FAIL illegal_load_fwd: op%0d got slot %0d holding a load, required slot >= %0d", i, sel, LOAD_SLOT);
        end
      end
    end
  end

  task automatic expect_v(input int kind, input int exp, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_src      = '0;
    id_src_used = '0;
    id_dst      = '0;
    id_wb_en    = 1'b0;
    id_is_load  = 1'b0;
  endtask

  task automatic ins(input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] used,
                     input logic [3:0] dst, input logic wb, input logic ld);
    id_valid    = 1'b1;
    id_src      = {s1, s0};
    id_src_used = used;
    id_dst      = dst;
    id_wb_en    = wb;
    id_is_load  = ld;
  endtask

  task automatic drain();
    idle();
    step(); step(); step();
  endtask

  // Writer of r followed by a dependent reader in stall-only mode: 2 stalls.
  task automatic pair_nofwd(input logic [3:0] r);
    fwd_en = 1'b0;
    ins(4'd0, 4'd0, 2'b00, r, 1'b1, 1'b0);
    step();
    ins(r, 4'd0, 2'b01, 4'd14, 1'b1, 1'b0);
    expect_v(K_STALL, 1, "pair_stall");
    step(); step(); step();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion before 100000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0; fwd_en = 1'b1;
    idle();
    step(); step();
    rst = 1'b0;

    // Reset state
    expect_v(K_STALL, 0, "reset_stall");
    expect_v(K_SEL0,  0, "reset_sel0");
    expect_v(K_SEL1,  0, "reset_sel1");
    expect_v(K_CNT,   0, "reset_count");

    // Back-to-back ALU: ADD r3,r1,r2 ; SUB r4,r3,r3
    ins(4'd1, 4'd2, 2'b11, 4'd3, 1'b1, 1'b0);
    expect_v(K_STALL, 0, "b2b_add_stall");
    step();
    ins(4'd3, 4'd3, 2'b11, 4'd4, 1'b1, 1'b0);
    expect_v(K_STALL, 0, "b2b_sub_stall");
    expect_v(K_SEL0,  0, "b2b_add_sel0");
    step();
    idle();
    expect_v(K_SEL0, 1, "b2b_sel0");
    expect_v(K_SEL1, 1, "b2b_sel1");
    drain();

    // Distance 2: write r5, unrelated, read r5
    ins(4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b0);
    step();
    ins(4'd0, 4'd0, 2'b00, 4'd6, 1'b1, 1'b0);
    step();
    ins(4'd5, 4'd0, 2'b01, 4'd7, 1'b1, 1'b0);
    expect_v(K_STALL, 0, "dist2_stall");
    step();
    idle();
    expect_v(K_SEL0, 2, "dist2_sel0");
    expect_v(K_SEL1, 0, "dist2_sel1_unused");
    drain();

    // r5 written in MEM and WB at once: newest (MEM) wins
    ins(4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b0);
    step();
    ins(4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b0);
    step();
    ins(4'd5, 4'd5, 2'b11, 4'd7, 1'b1, 1'b0);
    expect_v(K_STALL, 0, "newest_stall");
    step();
    idle();
    expect_v(K_SEL0, 1, "newest_sel0");
    expect_v(K_SEL1, 1, "newest_sel1");
    drain();

    // Load-use: LDR r2 ; ADD r1,r2,r0
    ins(4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b1);
    expect_v(K_STALL, 0, "lu_ldr_stall");
    step();
    ins(4'd2, 4'd0, 2'b11, 4'd1, 1'b1, 1'b0);
    expect_v(K_STALL, 1, "lu_stall_c1");
    step();
    expect_v(K_STALL, 0, "lu_stall_c2");
    expect_v(K_SEL0,  0, "lu_bubble_sel0");
    expect_v(K_CNT,   1, "lu_count_c2");
    step();
    idle();
    expect_v(K_SEL0,  2, "lu_sel0");
    expect_v(K_SEL1,  0, "lu_sel1");
    expect_v(K_STALL, 0, "lu_stall_c3");
    expect_v(K_CNT,   1, "lu_count");
    drain();

    // Stall-only mode: dependent pair costs 2 bubbles
    fwd_en = 1'b0;
    ins(4'd0, 4'd0, 2'b00, 4'd8, 1'b1, 1'b0);
    expect_v(K_STALL, 0, "nf_writer_stall");
    step();
    ins(4'd8, 4'd8, 2'b11, 4'd9, 1'b1, 1'b0);
    expect_v(K_STALL, 1, "nf_stall_c1");
    step();
    expect_v(K_STALL, 1, "nf_stall_c2");
    step();
    expect_v(K_STALL, 0, "nf_stall_c3");
    expect_v(K_CNT,   3, "nf_count_c3");
    step();
    idle();
    expect_v(K_SEL0, 0, "nf_sel0");
    expect_v(K_SEL1, 0, "nf_sel1");
    expect_v(K_CNT,  3, "nf_count");
    drain();

    // Flush during load-use stall
    fwd_en = 1'b1;
    ins(4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b1);
    step();
    ins(4'd2, 4'd0, 2'b01, 4'd1, 1'b1, 1'b0);
    flush = 1'b1;
    expect_v(K_STALL, 0, "flush_stall");
    step();
    flush = 1'b0;
    idle();
    expect_v(K_STALL, 0, "flush_next_stall");
    expect_v(K_SEL0,  0, "flush_bubble_sel0");
    expect_v(K_CNT,   3, "flush_count");
    drain();

    // Hold while stalled: no advance, no count
    ins(4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b1);
    step();
    ins(4'd4, 4'd4, 2'b11, 4'd5, 1'b1, 1'b0);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_v(K_STALL, 1, "hold_stall");
      expect_v(K_CNT,   3, "hold_count");
      step();
    end
    hold = 1'b0;
    expect_v(K_STALL, 1, "hold_release_stall");
    expect_v(K_CNT,   3, "hold_release_count");
    step();
    expect_v(K_STALL, 0, "hold_bubble_stall");
    expect_v(K_CNT,   4, "hold_bubble_count");
    step();
    idle();
    expect_v(K_SEL0, 2, "hold_sel0_pre");
    expect_v(K_SEL1, 2, "hold_sel1_pre");
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_v(K_SEL0, 2, "hold_sel0");
      expect_v(K_SEL1, 2, "hold_sel1");
      expect_v(K_CNT,  4, "hold_sel_count");
    end
    hold = 1'b0;
    drain();

    // Reset mid-stall
    ins(4'd0, 4'd0, 2'b00, 4'd6, 1'b1, 1'b1);
    step();
    ins(4'd6, 4'd6, 2'b11, 4'd7, 1'b1, 1'b0);
    expect_v(K_STALL, 1, "rst_pre_stall");
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_v(K_STALL, 0, "rst_stall");
    expect_v(K_SEL0,  0, "rst_sel0");
    expect_v(K_SEL1,  0, "rst_sel1");
    expect_v(K_CNT,   0, "rst_count");
    expect_v(K_CNTS,  0, "rst_count_sat");
    drain();

    // Unused operands matching a pending load
    ins(4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b1);
    step();
    ins(4'd2, 4'd2, 2'b00, 4'd1, 1'b1, 1'b0);
    expect_v(K_STALL, 0, "unused_stall");
    step();
    idle();
    expect_v(K_SEL0, 0, "unused_sel0");
    expect_v(K_SEL1, 0, "unused_sel1");
    drain();

    // Saturation: 8 stall-only stalls + 1 load-use stall
    pair_nofwd(4'd10);
    pair_nofwd(4'd11);
    pair_nofwd(4'd12);
    pair_nofwd(4'd13);
    expect_v(K_CNT,  8, "sat_count8_wide");
    expect_v(K_CNTS, 7, "sat_count8_narrow");
    fwd_en = 1'b1;
    ins(4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b1);
    step();
    ins(4'd2, 4'd0, 2'b01, 4'd1, 1'b1, 1'b0);
    step(); step();
    idle();
    expect_v(K_CNT,  9, "sat_count9_wide");
    expect_v(K_CNTS, 7, "sat_count9_narrow");
    step(); step();

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
